z180_io_bank: RTL and testbench



---
 rtl/z180_io_bank.sv | 106 ++++++++++
 tb/tb_z180_io_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/z180_io_bank.sv
// z180_io_bank: block of NUM_PORTS consecutive Z8S180 I/O byte ports at BASE_ADDR.
// Each port has an output latch, a sampled input path with optional latch
// read-back, and per-port read/write strobes. The block also inserts
// programmable wait states. All flops are clocked on the falling edge of phi.
module z180_io_bank #(
  parameter logic [7:0]           BASE_ADDR   = 8'hF0,
  parameter int unsigned          NUM_PORTS   = 4,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [7:0]           RESET_VALUE = 8'h00,
  parameter logic [NUM_PORTS-1:0] READBACK    = '0
) (
  input  logic                   phi,
  input  logic                   reset,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic [7:0]             a,
  input  logic [7:0]             d_in,
  output logic [7:0]             d_out,
  output logic                   d_oe,
  output logic                   wait_n,
  input  logic [8*NUM_PORTS-1:0] port_in,
  output logic [8*NUM_PORTS-1:0] port_out,
  output logic [NUM_PORTS-1:0]   rd_strobe,
  output logic [NUM_PORTS-1:0]   wr_strobe
);

  localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [8:0]  LO = {1'b0, BASE_ADDR};
  localparam logic [8:0]  HI = LO + 9'(NUM_PORTS);

  logic [IW-1:0] idx;
  logic          hit;
  logic          rd_acc;
  logic          wr_acc;
  logic          acc;
  logic [2:0]    cnt;
  logic [7:0]    rd_hold;
  logic [7:0]    live;
  logic [7:0]    port_q [NUM_PORTS];

  // Address decode and access qualification; simultaneous rd/wr is no access.
  always_comb begin
    hit    = ({1'b0, a} >= LO) && ({1'b0, a} < HI);
    idx    = (NUM_PORTS == 1) ? '0 : a[IW-1:0];
    rd_acc = ~iorq_n & ~rd_n &  wr_n & hit;
    wr_acc = ~iorq_n & ~wr_n &  rd_n & hit;
    acc    = rd_acc | wr_acc;
  end

  // Live read mux: latch read-back for masked ports, sampled input otherwise.
  always_comb begin
    live = READBACK[idx] ? port_q[idx] : port_in[{idx, 3'b000} +: 8];
  end

  // Bus drive: live value on the first cycle, frozen snapshot afterwards.
  always_comb begin
    d_oe  = rd_acc;
    d_out = 8'h00;
    if (rd_acc) d_out = (cnt == 3'd0) ? live : rd_hold;
  end

  // Pack the latch array onto the flat output bus.
  always_comb begin
    port_out = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) port_out[8*i +: 8] = port_q[i];
  end

  // Wait request while the access counter is below the configured count.
  generate
    if (WAIT_STATES == 0) begin : g_nowait
      assign wait_n = 1'b1;
    end else begin : g_wait
      assign wait_n = ~(acc & (32'(cnt) < WAIT_STATES));
    end
  endgenerate

  // Access counter: saturates at 7 so long accesses never produce a second tick.
  always_ff @(negedge phi or posedge reset) begin
    if (reset)           cnt <= '0;
    else if (!acc)       cnt <= '0;
    else if (cnt != 3'd7) cnt <= cnt + 3'd1;
  end

  // Read snapshot and strobe on the first edge, latch write on the second edge.
  always_ff @(negedge phi or posedge reset) begin
    if (reset) begin
      rd_hold   <= '0;
      rd_strobe <= '0;
      wr_strobe <= '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) port_q[i] <= RESET_VALUE;
    end else begin
      rd_strobe <= '0;
      wr_strobe <= '0;
      if (rd_acc && cnt == 3'd0) begin
        rd_hold        <= live;
        rd_strobe[idx] <= 1'b1;
      end
      if (wr_acc && cnt == 3'd1) begin
        port_q[idx]    <= d_in;
        wr_strobe[idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z180_io_bank.sv
// Self-checking bench for z180_io_bank: table of single-cycle vectors plus
// hand-written multi-cycle sequences (wait states, hold, readback, reset).
module tb_z180_io_bank;

  logic        phi = 1'b1;
  logic        reset;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  a, d_in, d_out;
  logic        d_oe, wait_n;
  logic [31:0] port_in, port_out;
  logic [3:0]  rd_strobe, wr_strobe;

  int n_chk  = 0;
  int n_pass = 0;
  int pulses;

  always #5 phi = ~phi;

  z180_io_bank #(
    .BASE_ADDR  (8'hF0),
    .NUM_PORTS  (4),
    .WAIT_STATES(2),
    .RESET_VALUE(8'h5A),
    .READBACK   (4'b0001)
  ) dut (
    .phi(phi), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .a(a), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .wait_n(wait_n),
    .port_in(port_in), .port_out(port_out),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe)
  );

  typedef struct {
    string      name;
    logic       iorq_n, rd_n, wr_n;
    logic [7:0] a;
    logic       e_oe;
    logic [7:0] e_dout;
    logic       e_wait;
    logic [3:0] e_rs, e_ws;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fall();
    @(negedge phi); #1;
  endtask

  task automatic bus(input logic io, input logic r, input logic w,
                     input logic [7:0] addr, input logic [7:0] data);
    @(posedge phi);
    iorq_n = io; rd_n = r; wr_n = w; a = addr; d_in = data;
  endtask

  task automatic idle_edge();
    bus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    fall();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"idle",      1, 0, 1, 8'hF0, 0, 8'h00, 1, 4'b0000, 4'b0000};
    vecs[1] = '{"rd_f0_rb",  0, 0, 1, 8'hF0, 1, 8'h5A, 0, 4'b0001, 4'b0000};
    vecs[2] = '{"rd_f1",     0, 0, 1, 8'hF1, 1, 8'h81, 0, 4'b0010, 4'b0000};
    vecs[3] = '{"rd_f2",     0, 0, 1, 8'hF2, 1, 8'h33, 0, 4'b0100, 4'b0000};
    vecs[4] = '{"rd_f3",     0, 0, 1, 8'hF3, 1, 8'h44, 0, 4'b1000, 4'b0000};
    vecs[5] = '{"rd_f4_oor", 0, 0, 1, 8'hF4, 0, 8'h00, 1, 4'b0000, 4'b0000};
    vecs[6] = '{"rd_ef_oor", 0, 0, 1, 8'hEF, 0, 8'h00, 1, 4'b0000, 4'b0000};
    vecs[7] = '{"rd_wr_low", 0, 0, 0, 8'hF0, 0, 8'h00, 1, 4'b0000, 4'b0000};
    vecs[8] = '{"wr_short",  0, 1, 0, 8'hF1, 0, 8'h00, 0, 4'b0000, 4'b0000};
    vecs[9] = '{"rd_noiorq", 1, 0, 1, 8'hF2, 0, 8'h00, 1, 4'b0000, 4'b0000};

    reset = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = 8'h00; d_in = 8'h00; port_in = 32'h44_33_81_11;
    fall(); fall();
    chk("rst_port_out", port_out, 32'h5A5A5A5A);
    chk("rst_rd_strobe", rd_strobe, 4'b0000);
    chk("rst_wr_strobe", wr_strobe, 4'b0000);
    chk("rst_wait_n", wait_n, 1'b1);
    chk("rst_d_oe", d_oe, 1'b0);
    @(posedge phi); reset = 1'b0;
    fall();

    // Table: one-cycle access, combinational outputs then registered strobes.
    foreach (vecs[i]) begin
      bus(vecs[i].iorq_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].a, 8'hEE);
      #1;
      chk({vecs[i].name, "_d_oe"},   d_oe,   vecs[i].e_oe);
      chk({vecs[i].name, "_d_out"},  d_out,  vecs[i].e_dout);
      chk({vecs[i].name, "_wait_n"}, wait_n, vecs[i].e_wait);
      fall();
      chk({vecs[i].name, "_rd_strobe"}, rd_strobe, vecs[i].e_rs);
      chk({vecs[i].name, "_wr_strobe"}, wr_strobe, vecs[i].e_ws);
      idle_edge();
    end
    chk("table_latches_held", port_out, 32'h5A5A5A5A);

    // Write C3 to F2 over three cycles, with two wait states.
    bus(1'b0, 1'b1, 1'b0, 8'hF2, 8'hC3);
    #1; chk("wr_wait_e0", wait_n, 1'b0);
    fall();
    chk("wr_po_e1", port_out, 32'h5A5A5A5A);
    chk("wr_ws_e1", wr_strobe, 4'b0000);
    chk("wr_wait_e1", wait_n, 1'b0);
    fall();
    chk("wr_po_e2", port_out, 32'h5AC35A5A);
    chk("wr_ws_e2", wr_strobe, 4'b0100);
    chk("wr_wait_e2", wait_n, 1'b1);
    fall();
    chk("wr_ws_e3", wr_strobe, 4'b0000);
    chk("wr_po_e3", port_out, 32'h5AC35A5A);
    idle_edge();

    // Read F1 while port_in changes after the first edge: data must hold.
    bus(1'b0, 1'b0, 1'b1, 8'hF1, 8'h00);
    #1; chk("hold_d_oe", d_oe, 1'b1); chk("hold_dout_e0", d_out, 8'h81);
    fall();
    chk("hold_rs_e1", rd_strobe, 4'b0010);
    chk("hold_dout_e1", d_out, 8'h81);
    port_in[15:8] = 8'h7E;
    #1; chk("hold_dout_chg", d_out, 8'h81);
    fall();
    chk("hold_rs_e2", rd_strobe, 4'b0000);
    chk("hold_dout_e2", d_out, 8'h81);
    fall();
    chk("hold_dout_e3", d_out, 8'h81);
    bus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    #1; chk("hold_end_d_oe", d_oe, 1'b0); chk("hold_end_dout", d_out, 8'h00);
    fall();

    // Readback port 0: write 3C then read it back regardless of port_in.
    bus(1'b0, 1'b1, 1'b0, 8'hF0, 8'h3C);
    fall(); fall();
    idle_edge();
    chk("rb_po", port_out, 32'h5AC35A3C);
    port_in[7:0] = 8'h99;
    bus(1'b0, 1'b0, 1'b1, 8'hF0, 8'h00);
    #1; chk("rb_dout_e0", d_out, 8'h3C);
    fall(); chk("rb_dout_e1", d_out, 8'h3C);
    idle_edge();

    // Ten-cycle write to F3: counter saturates, exactly one strobe.
    pulses = 0;
    bus(1'b0, 1'b1, 1'b0, 8'hF3, 8'h77);
    for (int unsigned k = 0; k < 10; k++) begin
      fall();
      if (wr_strobe != 4'b0000) pulses++;
    end
    chk("long_wr_pulses", pulses, 1);
    chk("long_wr_po", port_out, 32'h77C35A3C);
    chk("long_wr_wait", wait_n, 1'b1);
    idle_edge();

    // Two back-to-back reads of F3 with a single idle edge between them.
    pulses = 0;
    bus(1'b0, 1'b0, 1'b1, 8'hF3, 8'h00);
    fall(); if (rd_strobe == 4'b1000) pulses++;
    fall(); if (rd_strobe != 4'b0000) pulses++;
    idle_edge(); if (rd_strobe != 4'b0000) pulses++;
    bus(1'b0, 1'b0, 1'b1, 8'hF3, 8'h00);
    fall(); if (rd_strobe == 4'b1000) pulses++;
    idle_edge(); if (rd_strobe != 4'b0000) pulses++;
    chk("b2b_rd_pulses", pulses, 2);

    // Reset mid-write, then release with the write still active.
    bus(1'b0, 1'b1, 1'b0, 8'hF1, 8'hA5);
    fall(); fall();
    chk("mrst_pre_po", port_out, 32'h77C3A53C);
    #2 reset = 1'b1;
    #1;
    chk("mrst_po", port_out, 32'h5A5A5A5A);
    chk("mrst_ws", wr_strobe, 4'b0000);
    @(posedge phi); reset = 1'b0;
    fall();
    chk("mrst_rel_e1", port_out, 32'h5A5A5A5A);
    fall();
    chk("mrst_rel_e2", port_out, 32'h5A5AA55A);
    chk("mrst_rel_ws", wr_strobe, 4'b0010);
    idle_edge();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
